// File: rtl/axi_ocpoc_pwm_pkg.sv
// Shared constants for the OcPoC PWM AXI4-Lite slave: response codes,
// register word indices, index/counter widths and a byte-strobe merge helper.
package axi_ocpoc_pwm_pkg;

    localparam int unsigned IDX_W = 3;   // word index width (8 slots)
    localparam int unsigned CNT_W = 32;  // PWM counter / register width

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [IDX_W-1:0] REG_CTRL      = 3'd0;
    localparam logic [IDX_W-1:0] REG_PERIOD    = 3'd1;
    localparam logic [IDX_W-1:0] REG_DUTY_BASE = 3'd2;

    // Merge write data into the current value, one byte lane per strobe bit.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_ocpoc_pwm_core.sv
// PWM engine: shared period counter, double-buffered period/duty shadows
// reloaded at each wrap, and registered per-channel compare.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   enable       - per-channel enable (CTRL low bits)
//   period       - programmed period in clocks
//   duty         - programmed duty values, channel i at [32*i +: 32]
//   pwm_out      - registered PWM outputs
//   period_tick  - one-cycle pulse after each counter wrap
module axi_ocpoc_pwm_core
    import axi_ocpoc_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick
);

    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             period_act;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_act;
    logic                         wrap_c;

    assign wrap_c = (period_act != '0) && (cnt == period_act - CNT_W'(1));

    // Counter and shadow reload; a zero period parks the counter and keeps
    // the shadows tracking the programmed values every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_act  <= '0;
            duty_act    <= '0;
            period_tick <= 1'b0;
        end else if (period_act == '0) begin
            cnt         <= '0;
            period_act  <= period;
            duty_act    <= duty;
            period_tick <= 1'b0;
        end else if (wrap_c) begin
            cnt         <= '0;
            period_act  <= period;
            duty_act    <= duty;
            period_tick <= 1'b1;
        end else begin
            cnt         <= cnt + CNT_W'(1);
            period_tick <= 1'b0;
        end
    end

    // Registered compare; enable acts immediately, not at the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= enable[i] && (cnt < duty_act[i]);
            end
        end
    end

endmodule

// File: rtl/axi_ocpoc_pwm_lite_slave.sv
// AXI4-Lite slave for the OcPoC PWM controller: AXI handshakes, register
// file (CTRL, PERIOD, DUTY0..DUTYn-1) and the PWM core instance.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn - clock, async active-low reset
//   s00_axi_aw* / w* / b*          - AXI4-Lite write address/data/response
//   s00_axi_ar* / r*               - AXI4-Lite read address/data
//   pwm_out                        - NUM_CH PWM outputs
//   period_tick                    - pulse at each PWM counter wrap
// Build option: define AXI_OCPOC_PWM_SLVERR_EN to answer unmapped word
// slots with SLVERR instead of OKAY.
module axi_ocpoc_pwm_lite_slave
    import axi_ocpoc_pwm_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_CH             = 2
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH-1:0]               pwm_out,
    output logic                            period_tick
);

    localparam int unsigned NUM_REGS = 2 + NUM_CH;

`ifdef AXI_OCPOC_PWM_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    logic [CNT_W-1:0]             ctrl_q;
    logic [CNT_W-1:0]             period_q;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_q;

    logic [IDX_W-1:0] aw_idx_c;
    logic [IDX_W-1:0] ar_idx;
    logic             wr_fire_c;
    logic             rd_fire_c;
    logic             aw_mapped_c;
    logic             rd_mapped_c;
    logic [31:0]      rd_data_c;
    logic             unused_c;

    // Byte offset and protection bits carry no meaning here.
    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr, s00_axi_araddr};

    assign aw_idx_c    = s00_axi_awaddr[IDX_W+1:2];
    assign aw_mapped_c = 32'(aw_idx_c) < NUM_REGS;
    assign wr_fire_c   = s00_axi_awready && s00_axi_awvalid &&
                         s00_axi_wready  && s00_axi_wvalid;
    assign rd_fire_c   = s00_axi_arready && s00_axi_arvalid;

    // Write channel: joint AW/W accept pulse, then B held until bready.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
        end else begin
            s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid &&
                               !s00_axi_awready && !s00_axi_bvalid;
            s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid &&
                               !s00_axi_awready && !s00_axi_bvalid;
            if (wr_fire_c) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp  <= aw_mapped_c ? RESP_OKAY : UNMAPPED_RESP;
            end else if (s00_axi_bvalid && s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // Register file; unmapped slots simply match no register.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
        end else if (wr_fire_c) begin
            if (aw_idx_c == REG_CTRL) begin
                ctrl_q <= apply_wstrb(ctrl_q, s00_axi_wdata, s00_axi_wstrb);
            end
            if (aw_idx_c == REG_PERIOD) begin
                period_q <= apply_wstrb(period_q, s00_axi_wdata, s00_axi_wstrb);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (32'(aw_idx_c) == 32'(REG_DUTY_BASE) + 32'(i)) begin
                    duty_q[i] <= apply_wstrb(duty_q[i], s00_axi_wdata, s00_axi_wstrb);
                end
            end
        end
    end

    // Read mux on the latched read index.
    always_comb begin
        rd_data_c   = '0;
        rd_mapped_c = 32'(ar_idx) < NUM_REGS;
        if (ar_idx == REG_CTRL) begin
            rd_data_c = ctrl_q;
        end else if (ar_idx == REG_PERIOD) begin
            rd_data_c = period_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(ar_idx) == 32'(REG_DUTY_BASE) + 32'(i)) begin
                rd_data_c = duty_q[i];
            end
        end
    end

    // Read channel: data captured at the AR handshake edge, so a write
    // landing on the same edge is not visible in this response.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
            ar_idx          <= '0;
        end else begin
            s00_axi_arready <= s00_axi_arvalid && !s00_axi_arready && !s00_axi_rvalid;
            if (s00_axi_arvalid && !s00_axi_arready && !s00_axi_rvalid) begin
                ar_idx <= s00_axi_araddr[IDX_W+1:2];
            end
            if (rd_fire_c) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_data_c;
                s00_axi_rresp  <= rd_mapped_c ? RESP_OKAY : UNMAPPED_RESP;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    axi_ocpoc_pwm_core #(
        .NUM_CH (NUM_CH)
    ) u_core (
        .clk         (s00_axi_aclk),
        .rst_n       (s00_axi_aresetn),
        .enable      (ctrl_q[NUM_CH-1:0]),
        .period      (period_q),
        .duty        (duty_q),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

endmodule

// File: tb/tb_axi_ocpoc_pwm_lite_slave.sv
// Scoreboarded bench for axi_ocpoc_pwm_lite_slave: directed register, PWM and
// reset scenarios followed by randomized AXI traffic against a register model.
`timescale 1ns/1ps
module tb_axi_ocpoc_pwm_lite_slave;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned NREG   = 2 + NUM_CH;

`ifdef AXI_OCPOC_PWM_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
    logic        period_tick;

    always #5 clk = ~clk;

    axi_ocpoc_pwm_lite_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_CH             (NUM_CH)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .pwm_out         (pwm_out),
        .period_tick     (period_tick)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference register model: 8 word slots, only the first NREG writable.
    logic [31:0] model [8];

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];
    rexp_t      mon_r;

    function automatic logic [1:0] resp_for(input int idx);
        return (idx < NREG) ? 2'b00 : UNMAP_RESP;
    endfunction

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NREG) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        exp_b.push_back(resp_for(idx));
    endtask

    task automatic model_read(input logic [4:0] addr);
        int idx;
        rexp_t e;
        idx = int'(addr) / 4;
        e.data = model[idx];
        e.resp = resp_for(idx);
        exp_r.push_back(e);
    endtask

    // Monitors: compare every completed B / R beat against the queues.
    always @(negedge clk) begin
        #1;
        if (rst_n && bvalid && bready) begin
            if (exp_b.size() == 0) check("b_unexpected", bvalid, 1'b0);
            else check("bresp", bresp, exp_b.pop_front());
        end
        if (rst_n && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                check("r_unexpected", rvalid, 1'b0);
            end else begin
                mon_r = exp_r.pop_front();
                check("rdata", rdata, mon_r.data);
                check("rresp", rresp, mon_r.resp);
            end
        end
    end

    task automatic wait_aw(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (awready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        model_write(addr, data, strb);
        @(negedge clk);
        awaddr = addr; awprot = 3'($urandom); wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_aw(ok);
        check("aw_handshake", ok, 1'b1);
        check("wready_with_awready", wready, awready);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_latency", bvalid, 1'b1);
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [4:0] addr);
        bit ok;
        model_read(addr);
        @(negedge clk);
        araddr = addr; arprot = 3'($urandom); arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ar_handshake", ok, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_latency", rvalid, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int i;
        i = 0;
        @(negedge clk);
        while (!period_tick && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("tick_seen", period_tick, 1'b1);
    endtask

    // Count high samples from one tick up to (not including) the next.
    task automatic measure(output int len, output int hi0, output int hi1);
        len = 0; hi0 = 0; hi1 = 0;
        do begin
            if (pwm_out[0]) hi0++;
            if (pwm_out[1]) hi1++;
            len++;
            @(negedge clk);
        end while (!period_tick && len < 100);
    endtask

    function automatic int exp_hi(input bit en, input logic [31:0] per, input logic [31:0] duty);
        if (!en) return 0;
        return (duty >= per) ? int'(per) : int'(duty);
    endfunction

    task automatic check_outputs_zero(input string name);
        check(name, {awready, wready, bvalid, bresp, arready, rvalid, rresp, pwm_out, period_tick}, '0);
        check({name, "_rdata"}, rdata, 32'h0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int len, hi0, hi1, ticks;
        logic [31:0] per_snap, d0_snap;
        bit ok;
        for (int i = 0; i < 8; i++) model[i] = '0;

        // Reset state
        #12;
        check_outputs_zero("in_reset");
        #10 rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_release");

        // PWM: PERIOD=10, DUTY0=3, DUTY1=10, both channels enabled
        axi_write(5'h08, 32'd3, 4'hF);
        axi_write(5'h0C, 32'd10, 4'hF);
        axi_write(5'h00, 32'h3, 4'hF);
        axi_write(5'h04, 32'd10, 4'hF);
        wait_tick();
        for (int w = 0; w < 2; w++) begin
            measure(len, hi0, hi1);
            check("tick_spacing", len, 10);
            check("pwm0_high", hi0, exp_hi(model[0][0], model[1], model[2]));
            check("pwm1_high", hi1, exp_hi(model[0][1], model[1], model[3]));
        end

        // Mid-period DUTY0 change lands only after the next tick
        per_snap = model[1];
        d0_snap  = model[2];
        fork
            begin
                measure(len, hi0, hi1);
                check("mid_w1_len", len, 10);
                check("mid_w1_pwm0", hi0, exp_hi(1'b1, per_snap, d0_snap));
                measure(len, hi0, hi1);
                check("mid_w2_len", len, 10);
                check("mid_w2_pwm0", hi0, exp_hi(model[0][0], model[1], model[2]));
                check("mid_w2_pwm1", hi1, exp_hi(model[0][1], model[1], model[3]));
            end
            begin
                repeat (2) @(negedge clk);
                axi_write(5'h08, 32'd7, 4'hF);
            end
        join

        // Clearing CTRL[0] forces ch0 low without waiting for the wrap
        axi_write(5'h00, 32'h2, 4'hF);
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (pwm_out[0]) hi0++;
            if (pwm_out[1]) hi1++;
            @(negedge clk);
        end
        check("ctrl_clear_pwm0", hi0, 0);
        check("ctrl_clear_pwm1", hi1, 10);

        // Reset while bvalid=1 and pwm_out=1
        axi_write(5'h08, 32'd10, 4'hF);
        axi_write(5'h00, 32'h1, 4'hF);
        repeat (12) @(negedge clk);
        check("pwm_before_reset", pwm_out, 2'b01);
        @(negedge clk);
        awaddr = 5'h0C; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        wait_aw(ok);
        check("aw_before_reset", ok, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_before_reset", bvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < 8; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) axi_read(5'(4 * i));
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            if (period_tick) ticks++;
            @(negedge clk);
        end
        check("no_tick_period0", ticks, 0);

        // Register write / readback
        axi_write(5'h00, 32'h0101_FFFF, 4'hF);
        axi_write(5'h04, 32'hABCD_0001, 4'hF);
        axi_write(5'h08, 32'hDEAD_0011, 4'hF);
        axi_write(5'h0C, 32'hBEEF_0011, 4'hF);
        for (int i = 0; i < NREG; i++) axi_read(5'(4 * i));

        // Lone W waits for AW; B held while bready low blocks a second write
        model_write(5'h04, 32'h0000_1234, 4'hF);
        @(negedge clk);
        wdata = 32'h0000_1234; wstrb = 4'hF; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("lone_w_no_ready", {awready, wready}, 2'b00);
        end
        awaddr = 5'h04; awvalid = 1'b1;
        wait_aw(ok);
        check("aw_after_w", ok, 1'b1);
        @(negedge clk);
        model_write(5'h0C, 32'h0000_5678, 4'hF);
        awaddr = 5'h0C; wdata = 32'h0000_5678;
        repeat (5) begin
            check("bvalid_held", bvalid, 1'b1);
            check("no_accept_during_b", awready, 1'b0);
            @(negedge clk);
        end
        bready = 1'b1;
        wait_aw(ok);
        check("second_write_accepted", ok, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_second", bvalid, 1'b1);
        @(negedge clk);

        // Byte strobe on DUTY0
        axi_write(5'h08, 32'hFFFF_FFFF, 4'b0010);
        for (int i = 0; i < NREG; i++) axi_read(5'(4 * i));

        // Read and write to the same register on the same edge
        fork
            axi_read(5'h08);
            begin
                #1;
                axi_write(5'h08, 32'h5555_AAAA, 4'hF);
            end
        join
        axi_read(5'h08);

        // Unmapped slots
        axi_read(5'h14);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h1C);
        for (int i = 0; i < NREG; i++) axi_read(5'(4 * i));

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            int op;
            a  = 5'($urandom);
            d  = $urandom;
            s  = 4'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) begin
                axi_write(a, d, s);
            end else if (op == 1) begin
                axi_read(a);
            end else begin
                fork
                    axi_read(a);
                    begin
                        #1;
                        axi_write(a, d, s);
                    end
                join
            end
        end
        for (int i = 0; i < 8; i++) axi_read(5'(4 * i));

        repeat (3) @(negedge clk);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
